// File: rtl/hazard_controller_if.sv
// ============================================================================
// hazard_controller_if : pipeline hazard sequencing bundle (ID/EX status in,
// PC / pipeline-register controls out).  Rev 1.0
// ============================================================================
`default_nettype none

interface hazard_controller_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_is_mul;
  logic [4:0]  ex_rd;
  logic        ex_mem_read;
  logic        branch_taken;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        ex_hold;
  logic        ex_mem_bubble;
  logic        mul_busy;
  logic [15:0] stall_cycles;

  // The controller is the master: it drives the pipeline control signals.
  modport master (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul,
           ex_rd, ex_mem_read, branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           ex_mem_bubble, mul_busy, stall_cycles
  );

  modport slave (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_mul,
           ex_rd, ex_mem_read, branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold,
           ex_mem_bubble, mul_busy, stall_cycles
  );
endinterface

`default_nettype wire

// File: rtl/hazard_controller.sv
// ============================================================================
// hazard_controller : load-use / branch-flush / multi-cycle multiply sequencer
// with saturating stall-cycle counter.  Rev 1.0
// ============================================================================
`default_nettype none

module hazard_controller #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  hazard_controller_if.master hz
);

  typedef enum logic [0:0] {
    ST_RUN = 1'b0,
    ST_MUL = 1'b1
  } state_t;

  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);
  localparam bit         MUL_MULTI    = (MUL_LATENCY > 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_q;
  logic        load_use;

  assign load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) && hz.id_valid &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.ex_rd)));

  always_comb begin
    hz.pc_write      = 1'b1;
    hz.if_id_write   = 1'b1;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_bubble  = 1'b0;
    hz.ex_hold       = 1'b0;
    hz.ex_mem_bubble = 1'b0;
    hz.mul_busy      = 1'b0;
    state_d          = state_q;
    cnt_d            = cnt_q;

    if (reset) begin
      hz.pc_write      = 1'b0;
      hz.if_id_write   = 1'b0;
      hz.if_id_flush   = 1'b1;
      hz.id_ex_bubble  = 1'b1;
      hz.ex_mem_bubble = 1'b1;
      state_d          = ST_RUN;
      cnt_d            = 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (hz.branch_taken) begin
            // A multiply sitting in ID is squashed along with the rest of ID.
            hz.if_id_flush  = 1'b1;
            hz.id_ex_bubble = 1'b1;
          end else if (load_use) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_ex_bubble = 1'b1;
          end else if (hz.id_valid && hz.id_is_mul && MUL_MULTI) begin
            state_d = ST_MUL;
            cnt_d   = MUL_CNT_INIT;
          end
        end
        ST_MUL: begin
          hz.pc_write      = 1'b0;
          hz.if_id_write   = 1'b0;
          hz.ex_hold       = 1'b1;
          hz.ex_mem_bubble = 1'b1;
          hz.mul_busy      = 1'b1;
          cnt_d            = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!hz.pc_write && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
  end

  assign hz.stall_cycles = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// ============================================================================
// tb_hazard_controller : directed bench for hazard_controller at MUL_LATENCY
// 4 and 1, checked cycle by cycle against a behavioural model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_uses_rs, id_uses_rt, id_is_mul;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        ex_mem_read, branch_taken;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_controller_if if4 ();
  hazard_controller_if if1 ();

  assign if4.id_valid = id_valid;       assign if1.id_valid = id_valid;
  assign if4.id_rs = id_rs;             assign if1.id_rs = id_rs;
  assign if4.id_rt = id_rt;             assign if1.id_rt = id_rt;
  assign if4.id_uses_rs = id_uses_rs;   assign if1.id_uses_rs = id_uses_rs;
  assign if4.id_uses_rt = id_uses_rt;   assign if1.id_uses_rt = id_uses_rt;
  assign if4.id_is_mul = id_is_mul;     assign if1.id_is_mul = id_is_mul;
  assign if4.ex_rd = ex_rd;             assign if1.ex_rd = ex_rd;
  assign if4.ex_mem_read = ex_mem_read; assign if1.ex_mem_read = ex_mem_read;
  assign if4.branch_taken = branch_taken; assign if1.branch_taken = branch_taken;

  hazard_controller #(.MUL_LATENCY(4)) dut4 (.clk(clk), .reset(reset), .hz(if4));
  hazard_controller #(.MUL_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .hz(if1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles of multiply busy still to come, and stall count per DUT.
  int rem [2] = '{0, 0};
  int stl [2] = '{0, 0};
  int lat [2] = '{4, 1};

  function automatic bit lu_now();
    return ex_mem_read && (ex_rd != 0) && id_valid &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  // {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_hold, ex_mem_bubble, mul_busy}
  function automatic logic [6:0] exp_ctrl(input int r);
    if (reset)        return 7'b0011010;
    if (r > 0)        return 7'b0000111;
    if (branch_taken) return 7'b1111000;
    if (lu_now())     return 7'b0001000;
    return 7'b1100000;
  endfunction

  function automatic logic [6:0] act_ctrl(input int k);
    if (k == 0)
      return {if4.pc_write, if4.if_id_write, if4.if_id_flush, if4.id_ex_bubble,
              if4.ex_hold, if4.ex_mem_bubble, if4.mul_busy};
    return {if1.pc_write, if1.if_id_write, if1.if_id_flush, if1.id_ex_bubble,
            if1.ex_hold, if1.ex_mem_bubble, if1.mul_busy};
  endfunction

  always @(posedge clk) begin
    logic [6:0] e;
    for (int k = 0; k < 2; k++) begin
      e = exp_ctrl(rem[k]);
      if (reset) begin
        rem[k] <= 0;
        stl[k] <= 0;
      end else begin
        if (!e[6] && stl[k] < 65535) stl[k] <= stl[k] + 1;
        if (rem[k] > 0) rem[k] <= rem[k] - 1;
        else if (!branch_taken && !lu_now() && id_valid && id_is_mul) rem[k] <= lat[k] - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("ctrl_lat4", {25'd0, act_ctrl(0)}, {25'd0, exp_ctrl(rem[0])});
    chk("ctrl_lat1", {25'd0, act_ctrl(1)}, {25'd0, exp_ctrl(rem[1])});
    chk("stall_lat4", {16'd0, if4.stall_cycles}, stl[0]);
    chk("stall_lat1", {16'd0, if1.stall_cycles}, stl[1]);
  end

  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_is_mul = 0;
    id_rs = 0; id_rt = 0; ex_rd = 0; ex_mem_read = 0; branch_taken = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lu5();
    ex_mem_read = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1; id_valid = 1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s0;
    reset = 1;
    idle();
    @(negedge clk);
    chk("reset_pc_write", {31'd0, if4.pc_write}, 0);
    chk("reset_flush", {31'd0, if4.if_id_flush}, 1);
    chk("reset_exmem_bubble", {31'd0, if4.ex_mem_bubble}, 1);
    step();
    reset = 0;
    step();

    // Load-use on rs
    set_lu5();
    @(negedge clk);
    chk("lu_pc_write", {31'd0, if4.pc_write}, 0);
    chk("lu_if_id_write", {31'd0, if4.if_id_write}, 0);
    chk("lu_bubble", {31'd0, if4.id_ex_bubble}, 1);
    chk("lu_stall_before", {16'd0, if4.stall_cycles}, 0);
    step();
    idle();
    @(negedge clk);
    chk("lu_stall_after", {16'd0, if4.stall_cycles}, 1);
    step();

    // Register 0 and unused-source cases must not stall
    set_lu5(); ex_rd = 0; id_rs = 0;
    @(negedge clk);
    chk("r0_pc_write", {31'd0, if4.pc_write}, 1);
    chk("r0_bubble", {31'd0, if4.id_ex_bubble}, 0);
    step();
    set_lu5(); id_uses_rs = 0;
    @(negedge clk);
    chk("unused_rs_pc_write", {31'd0, if4.pc_write}, 1);
    step();
    set_lu5(); id_uses_rs = 0; id_rs = 7; id_rt = 5; id_uses_rt = 1;
    step();
    set_lu5(); id_valid = 0;
    step();

    // Branch beats load-use and a multiply in ID
    idle(); set_lu5(); branch_taken = 1; id_is_mul = 1;
    @(negedge clk);
    chk("br_flush", {31'd0, if4.if_id_flush}, 1);
    chk("br_bubble", {31'd0, if4.id_ex_bubble}, 1);
    chk("br_pc_write", {31'd0, if4.pc_write}, 1);
    step();
    idle();
    @(negedge clk);
    chk("br_no_mul", {31'd0, if4.mul_busy}, 0);
    step();

    // Multiply: branch / load-use during MUL are ignored by the 4-cycle unit
    idle(); id_valid = 1; id_is_mul = 1;
    s0 = if4.stall_cycles;
    @(negedge clk);
    chk("mul_t0_pc_write", {31'd0, if4.pc_write}, 1);
    step();
    idle(); branch_taken = 1;
    @(negedge clk);
    chk("mul_t1_busy", {31'd0, if4.mul_busy}, 1);
    chk("mul_t1_hold", {31'd0, if4.ex_hold}, 1);
    chk("mul_t1_lat1_busy", {31'd0, if1.mul_busy}, 0);
    step();
    idle(); set_lu5();
    step();
    idle();
    @(negedge clk);
    chk("mul_t3_busy", {31'd0, if4.mul_busy}, 1);
    chk("mul_t3_pc_write", {31'd0, if4.pc_write}, 0);
    step();
    @(negedge clk);
    chk("mul_t4_busy", {31'd0, if4.mul_busy}, 0);
    chk("mul_t4_stall", {16'd0, if4.stall_cycles}, 32'(s0) + 3);
    step();

    // Load-use holds off a multiply until the hazard clears
    set_lu5(); id_is_mul = 1;
    step();
    ex_mem_read = 0;
    step();
    idle();
    @(negedge clk);
    chk("mul_after_lu_busy", {31'd0, if4.mul_busy}, 1);
    repeat (4) step();

    // Reset in the middle of a multiply
    id_valid = 1; id_is_mul = 1;
    step();
    idle();
    step();
    reset = 1;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, if4.mul_busy}, 0);
    chk("rst_mid_flush", {31'd0, if4.if_id_flush}, 1);
    step();
    reset = 0;
    @(negedge clk);
    chk("post_rst_busy", {31'd0, if4.mul_busy}, 0);
    chk("post_rst_stall", {16'd0, if4.stall_cycles}, 0);
    step();

    // Saturation of the stall counter
    set_lu5();
    repeat (70000) step();
    @(negedge clk);
    chk("sat_stall", {16'd0, if4.stall_cycles}, 32'hFFFF);
    step();
    step();
    @(negedge clk);
    chk("sat_stall_hold", {16'd0, if4.stall_cycles}, 32'hFFFF);
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the 4-stage MIPS core (IF, ID, EX, MEM/WB). It decides each cycle whether the PC and the pipeline registers advance, hold, or take a bubble or flush. It covers three cases: load-use hazards, taken-branch flushes and the multi-cycle multiply that occupies EX. It sits beside the EX/MEM forwarding unit and drives the write-enable and bubble controls of the PC and the IF/ID, ID/EX and EX/MEM registers. It also keeps a saturating stall-cycle performance counter.

## Interface
- MUL_LATENCY, 4, total EX-stage cycles of a multiply (legal 1..15)
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_is_mul  in  1  ID instruction is a multiply
- ex_rd  in  5  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- branch_taken  in  1  EX resolved a taken branch this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID write enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_bubble  out  1  load NOP into ID/EX instead of ID contents
- ex_hold  out  1  freeze ID/EX (multiply held in EX)
- ex_mem_bubble  out  1  load NOP into EX/MEM
- mul_busy  out  1  multiply sequencing in progress
- stall_cycles  out  16  registered count of cycles with pc_write=0

## Operation
- State: RUN or MUL, plus 4-bit down-counter cnt. All outputs except stall_cycles are combinational from state, cnt and inputs.
- Load-use hazard: load_use = ex_mem_read & ex_rd!=0 & id_valid & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- RUN, priority order:
  1. branch_taken: if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1. A multiply in ID is squashed and MUL is not entered.
  2. load_use: pc_write=0, if_id_write=0, id_ex_bubble=1. MUL is not entered even if id_is_mul=1; the multiply issues after the hazard clears.
  3. Otherwise all enables are 1 and bubble/flush are 0. If id_valid & id_is_mul & MUL_LATENCY>1, the next state is MUL with cnt=MUL_LATENCY-1.
- In RUN: ex_hold=0, ex_mem_bubble=0, mul_busy=0.
- MUL:
  - Outputs: pc_write=0, if_id_write=0, ex_hold=1, ex_mem_bubble=1, mul_busy=1, id_ex_bubble=0, if_id_flush=0.
  - branch_taken and load_use are ignored.
  - cnt decrements each cycle. When cnt==1, the next state is RUN and cnt becomes 0.
- stall_cycles increments by 1 on each non-reset cycle where pc_write=0. It saturates at 0xFFFF.
- Reset:
  - While reset=1, outputs are forced to: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, ex_hold=0, ex_mem_bubble=1, mul_busy=0.
  - On the edge: state=RUN, cnt=0, stall_cycles=0.
  - Reset during MUL aborts the multiply immediately.

## Timing
- Hazard and flush responses have zero latency: they are asserted in the same cycle the condition is present.
- Load-use stalls last exactly 1 cycle. The next cycle the load is in MEM, EX holds a bubble, and load_use deasserts.
- Multiply, with ID at cycle t0:
  - t0: normal advance.
  - t0+1 .. t0+MUL_LATENCY-1: MUL state (MUL_LATENCY-1 cycles, mul_busy high).
  - t0+MUL_LATENCY: RUN; the multiply leaves EX at the end of that cycle.
  - EX occupancy is MUL_LATENCY cycles in total.
- MUL_LATENCY=1: MUL is never entered; the multiply behaves as a single-cycle op.
- stall_cycles updates one cycle after the qualifying cycle.

## Test plan
- Load-use hazard: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1, id_valid=1 → that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cycles=1 next cycle.
- No hazard on register 0: same stimulus with ex_rd=0, id_rs=0 → pc_write=1, id_ex_bubble=0. With id_uses_rs=0 and id_rs=ex_rd=5 → no stall.
- Branch over hazard: branch_taken=1 together with load_use=1 and id_is_mul=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1; state stays RUN, mul_busy=0 next cycle.
- Multiply, MUL_LATENCY=4: id_is_mul=1, id_valid=1 at t0 → mul_busy/ex_hold/ex_mem_bubble=1 at t0+1..t0+3, pc_write=0 for those 3 cycles; RUN at t0+4; stall_cycles=3. With MUL_LATENCY=1 → never busy.
- Reset mid-multiply: reset=1 at t0+2 → forced reset output values that cycle; at t0+3 with reset=0, state is RUN, mul_busy=0, stall_cycles=0.
- Counter saturation: hold load_use true for 70000 cycles → stall_cycles reads 0xFFFF and stays there.
